// File: rtl/reg_port_pkg.sv
// Shared types and constants for the register-file port controller.
package reg_port_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  // Register-file reg_write encodings.
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_RS   = 2'b01;
  localparam logic [1:0] RW_RT   = 2'b10;

  // One pending writeback at the default widths.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } hold_t;

endpackage

// File: rtl/reg_port_if.sv
// Bundle of writeback, decode-read and register-file signals around reg_port_ctrl.
interface reg_port_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  // Handshake: a writeback transfers at a rising edge where valid & ready are
  // both high; ready may depend combinationally on valid/addr of the same
  // cycle, valid must not depend on ready. rd_ready grants the read in the
  // current cycle with rd_data1/rd_data2 valid in that same cycle.
  logic              wb0_valid;
  logic              wb0_ready;
  logic [ADDR_W-1:0] wb0_addr;
  logic [DATA_W-1:0] wb0_data;
  logic              wb1_valid;
  logic              wb1_ready;
  logic [ADDR_W-1:0] wb1_addr;
  logic [DATA_W-1:0] wb1_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_rs;
  logic [ADDR_W-1:0] rd_rt;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  logic [ADDR_W-1:0] rf_rs;
  logic [ADDR_W-1:0] rf_rt;
  logic [1:0]        rf_reg_write;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] reg_val1;
  logic [DATA_W-1:0] reg_val2;

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    output rd_valid, rd_rs, rd_rt,
    output reg_val1, reg_val2,
    input  wb0_ready, wb1_ready, rd_ready, rd_data1, rd_data2,
    input  rf_rs, rf_rt, rf_reg_write, rf_write_data
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    input  rd_valid, rd_rs, rd_rt,
    input  reg_val1, reg_val2,
    output wb0_ready, wb1_ready, rd_ready, rd_data1, rd_data2,
    output rf_rs, rf_rt, rf_reg_write, rf_write_data
  );

endinterface

// File: rtl/reg_port_rr_arb.sv
// Two-way round-robin arbiter; on contention the port not granted last wins.
module reg_port_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset value 1 means port 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= 1'b1;
    else if (|grant)
      last_grant <= grant[1];
  end

endmodule

// File: rtl/reg_port_ctrl.sv
// Shares the register file's single write path (stolen rs port) between two
// writeback ports and the decode read. REG_PORT_STARVE_GUARD_EN enables the read starve guard.
module reg_port_ctrl #(
  parameter int ADDR_W       = reg_port_pkg::ADDR_W,
  parameter int DATA_W       = reg_port_pkg::DATA_W,
  parameter int STARVE_LIMIT = 2
) (
  input logic       clk,
  input logic       rst,
  reg_port_if.slave bus
);

  import reg_port_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            hold0;
  entry_t            hold1;
  entry_t            iss;
  logic [1:0]        grant;
  logic              last_grant;
  logic              issue;
  logic              guard;
  logic              hz;
  logic              clash0;
  logic              clash1;
  logic              ready0;
  logic              ready1;
  logic              acc0;
  logic              acc1;

  function automatic logic hit(input entry_t e, input logic [ADDR_W-1:0] a);
    return e.valid && (a != '0) && (e.addr == a);
  endfunction

  assign hz = hit(hold0, bus.rd_rs) | hit(hold0, bus.rd_rt) |
              hit(hold1, bus.rd_rs) | hit(hold1, bus.rd_rt);

  reg_port_rr_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({hold1.valid, hold0.valid}),
    .enable     (!guard),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign issue = |grant;
  assign iss   = grant[1] ? hold1 : hold0;

  // A port may not accept a register the other side still owes the file,
  // otherwise two writes to one register could land out of order.
  assign clash0 = hold1.valid && (bus.wb0_addr != '0) && (bus.wb0_addr == hold1.addr);
  assign ready0 = !rst && (!hold0.valid || grant[0]) && !clash0;
  assign acc0   = bus.wb0_valid && ready0;

  assign clash1 = (bus.wb1_addr != '0) &&
                  ((hold0.valid && (bus.wb1_addr == hold0.addr)) ||
                   (acc0 && (bus.wb1_addr == bus.wb0_addr)));
  assign ready1 = !rst && (!hold1.valid || grant[1]) && !clash1;
  assign acc1   = bus.wb1_valid && ready1;

  assign bus.wb0_ready = ready0;
  assign bus.wb1_ready = ready1;
  assign bus.rd_ready  = !rst && bus.rd_valid && !hz && !issue;
  assign bus.rd_data1  = bus.reg_val1;
  assign bus.rd_data2  = bus.reg_val2;

  // Writes to r0 are swallowed: accepted but never held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (acc0 && (bus.wb0_addr != '0))
        hold0 <= '{1'b1, bus.wb0_addr, bus.wb0_data};
      else if (grant[0])
        hold0.valid <= 1'b0;

      if (acc1 && (bus.wb1_addr != '0))
        hold1 <= '{1'b1, bus.wb1_addr, bus.wb1_data};
      else if (grant[1])
        hold1.valid <= 1'b0;
    end
  end

`ifdef REG_PORT_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] sc;

  // sc counts writes that pushed back a hazard-free waiting read; it never
  // passes STARVE_LIMIT because the guard blocks the write that would.
  assign guard = bus.rd_valid && !hz && (sc == SC_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sc <= '0;
    else if (!bus.rd_valid || bus.rd_ready)
      sc <= '0;
    else if (!hz && issue)
      sc <= sc + 1'b1;
  end
`else
  // Writes always win; the limit has no effect in this build.
  assign guard = 1'b0 && (STARVE_LIMIT > 0);
`endif

  always_comb begin
    bus.rf_rs         = bus.rd_rs;
    bus.rf_rt         = bus.rd_rt;
    bus.rf_reg_write  = RW_NONE;
    bus.rf_write_data = '0;
    if (rst) begin
      bus.rf_rs = '0;
      bus.rf_rt = '0;
    end else if (issue) begin
      bus.rf_rs         = iss.addr;
      bus.rf_reg_write  = RW_RS;
      bus.rf_write_data = iss.data;
    end
  end

endmodule
